digit_entry_display: RTL
========================

Name: digit_entry_display

Overview:
- Consumer end of the control-unit interface: takes the 2-bit digit select {sel_2, sel_1} and the registered `load` level, and writes the 4-bit switch value into the selected digit of a 4-digit register.
- Drives the board's multiplexed, active-low 4-digit seven-segment display from that register.
- Blinks the currently selected digit so the user sees where the next load lands.
- Sits between the CU outputs / board switches and the display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per scan step (one digit lit per step).
- BLINK_DIV, 25000000, clk cycles per blink half-period of the selected digit.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sel_1  input  1  digit select bit 0 (LSB), from CU
- sel_2  input  1  digit select bit 1 (MSB), from CU
- load  input  1  write request level from CU; acts on its rising edge only
- sw  input  4  BCD value to write
- digits  output  16  stored digits; digit k at [4k+3:4k]
- an  output  4  anode enables, active-low, one-hot-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- err  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Clocking: one clock domain (clk). reset_n is asynchronous and active-low; all state clears immediately on assertion.
- Reset values:
  - digits=16'h0000, an=4'b1111, seg=7'b1111111, err=0.
  - Scan index=0, refresh/blink prescalers=0, blink phase=0.
  - load_q (previous load sample)=1, so a load held through reset release does not cause a write.
- Write path:
  - write_evt = load & ~load_q, evaluated every clk. load_q <= load every cycle.
  - Target index = {sel_2, sel_1}, sampled in the same cycle as write_evt.
  - On write_evt with sw<=9: digits[index] <= sw at the next edge; err stays 0.
  - On write_evt with sw>=10: no write; err=1 for exactly one cycle.
  - Exactly one write per rising edge of load, however long load is held.
  - A select change in the same cycle as write_evt: the new select value is used.
- Scan:
  - Refresh prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and scan index increments mod 4 (3 -> 0).
  - an and seg are registered. In each cycle:
    - an <= ~(4'b0001 << scan).
    - seg <= decode(digits[scan]), or blank (7'b1111111) when scan == {sel_2, sel_1} and blink phase=1.
  - Latency: an/seg reflect scan index and digit contents one cycle after they change. A write becomes visible on seg 2 cycles after write_evt, if that digit is being scanned.
- Blink:
  - Blink prescaler counts 0..BLINK_DIV-1 and toggles blink phase at terminal count.
  - Blanking follows the live select with one-cycle latency; there is no blink restart on select change.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Stored values are always 0-9; the decoder's default case is blank.
- Reset mid-operation: display blanks immediately; after release the first scan step shows digit 0 on the cycle after the first clk edge.

Decomposition:
- Package disp_pkg:
  - NUM_DIGITS=4, DIGIT_W=4, SEG_W=7.
  - SEG_BLANK=7'b1111111.
  - Segment pattern constants SEG_0..SEG_9.
- One combinational sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out, blank default). Instantiated once on the scan-mux output.
- Prescalers, scan counter, edge detect and digit register stay in the top module.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
- Reset release with load low:
  - an cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, stepping every 4 cycles.
  - seg=1000000 on every unblanked step; digits=0000.
- sel=2'b10, sw=4'd7, load held high 10 cycles:
  - Exactly one write; digits=16'h0700; err stays 0.
  - When an=1011 and blink phase=0, seg=1111000.
- sel=2'b01, sw=4'd12, load rising edge:
  - err high for exactly 1 cycle; digits unchanged.
- sel=2'b00, observe 40 cycles:
  - While an=1110, seg alternates between the digit-0 pattern and 1111111, toggling every 16 cycles.
  - Other digits are never blanked.
- load held high across a reset_n low pulse:
  - After release, no write occurs.
  - Dropping then raising load writes once.
- Reset asserted mid-scan with digits=16'h9321:
  - an=1111, seg=1111111 and digits=0000 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the digit entry / seven-segment display slice.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

  // Blink phase of the selected digit: shown or blanked.
  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_BLANK = 1'b1
  } blink_ph_e;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decoder.
//   bcd : 4-bit BCD digit
//   seg : segments {g,f,e,d,c,b,a}, active-low; non-BCD codes give blank
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_entry_display.sv
// Digit entry register with multiplexed 4-digit seven-segment display.
// The rising edge of load writes sw into digit {sel_2,sel_1}; non-BCD
// values are rejected with a one-cycle err pulse. The selected digit blinks.
//   clk, reset_n : clock, asynchronous active-low reset
//   sel_1, sel_2 : digit select (LSB, MSB)
//   load         : write request level, edge-detected
//   sw           : value to write
//   digits       : stored digits, digit k at [4k+3:4k]
//   an           : anode enables, active-low, one-hot-low
//   seg          : segments {g,f,e,d,c,b,a}, active-low
//   err          : one-cycle pulse on a rejected write
module digit_entry_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sel_1,
  input  logic                          sel_2,
  input  logic                          load,
  input  logic [DIGIT_W-1:0]            sw,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [SEG_W-1:0]              seg,
  output logic                          err
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic            load_q;
  logic            write_evt;
  logic            sw_ok;
  logic [1:0]      sel_idx;
  logic [RW-1:0]   ref_cnt;
  logic [BW-1:0]   blink_cnt;
  blink_ph_e       blink_ph;
  logic [1:0]      scan;
  logic [DIGIT_W-1:0] scan_digit;
  logic [SEG_W-1:0]   dec_seg;

  assign sel_idx    = {sel_2, sel_1};
  assign write_evt  = load & ~load_q;
  assign sw_ok      = (sw <= 4'd9);
  assign scan_digit = digits[int'(scan)*DIGIT_W +: DIGIT_W];

  seg7_decoder u_dec (
    .bcd (scan_digit),
    .seg (dec_seg)
  );

  // load_q resets high so a load level held through reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q <= 1'b1;
      digits <= '0;
      err    <= 1'b0;
    end else begin
      load_q <= load;
      err    <= write_evt & ~sw_ok;
      if (write_evt && sw_ok)
        digits[int'(sel_idx)*DIGIT_W +: DIGIT_W] <= sw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      scan    <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      scan    <= scan + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_ph  <= PH_SHOW;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= (blink_ph == PH_SHOW) ? PH_BLANK : PH_SHOW;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Registered display drive: one cycle behind scan index and digit contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << scan);
      seg <= (blink_ph == PH_BLANK && scan == sel_idx) ? SEG_BLANK : dec_seg;
    end
  end

endmodule
